// File: rtl/decimation_controller.sv
// -----------------------------------------------------------------------------
// decimation_controller
//
// Sequencer for the moving-average decimator datapath. It arms an acquisition,
// latches the decimation exponent at a block boundary, gates ADC strobes into
// the averager, counts decimated outputs up to a programmed length and pulses
// done on completion.
//
// Strobe semantics: adc_rdy, avg_rdy and avg_rdy_in are single-cycle
// qualifiers with no back-pressure. A strobe is consumed in the cycle it is
// high. There is no ready/acknowledge path, so a strobe outside RUN is lost.
//
// Ports
//   clk          fpga clock
//   rst          asynchronous, active-high reset
//   start        one-cycle pulse, arms an acquisition (IDLE only)
//   stop         one-cycle pulse, aborts; beats a coincident start
//   k_req        requested decimation exponent (sampled at accepted start)
//   num_samples  decimated outputs to collect, 0 = continuous
//   adc_rdy      raw ADC sample strobe
//   avg_rdy      averager output strobe (rdy_out)
//   avg_rst      registered synchronous reset to the averager
//   avg_k        registered exponent applied to the averager
//   avg_rdy_in   adc_rdy gated by RUN (combinational)
//   busy         high in FLUSH and RUN
//   done         one-cycle completion pulse
//   out_count    decimated outputs counted this acquisition
//   k_clamped    last latched k_req exceeded BIT_DIFF-1
//   state_dbg    current FSM state (IDLE=0, FLUSH=1, RUN=2, DONE=3)
// -----------------------------------------------------------------------------
module decimation_controller #(
    parameter int BITS_ADC  = 8,
    parameter int BITS_ACUM = 12,
    parameter int BITS_CNT  = 16,
    localparam int BIT_DIFF = BITS_ACUM - BITS_ADC,
    localparam int KW       = (BIT_DIFF > 1) ? $clog2(BIT_DIFF) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic [KW-1:0]       k_req,
    input  logic [BITS_CNT-1:0] num_samples,
    input  logic                adc_rdy,
    input  logic                avg_rdy,
    output logic                avg_rst,
    output logic [KW-1:0]       avg_k,
    output logic                avg_rdy_in,
    output logic                busy,
    output logic                done,
    output logic [BITS_CNT-1:0] out_count,
    output logic                k_clamped,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Largest exponent the averager accumulator can absorb without overflow.
    localparam int K_MAX = BIT_DIFF - 1;

    state_t              state;
    logic [BITS_CNT-1:0] target;
    logic [BITS_CNT-1:0] cnt_inc;
    logic                k_over;

    // Wraps naturally at 2^BITS_CNT, which is the continuous-mode behaviour.
    always_comb begin
        cnt_inc = out_count + BITS_CNT'(1);
    end

    always_comb begin
        k_over = (int'(k_req) > K_MAX);
    end

    // Only combinational output: the averager must see the strobe in the
    // same cycle the ADC presents it.
    assign avg_rdy_in = adc_rdy & (state == RUN);
    assign state_dbg  = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            avg_rst   <= 1'b1;
            avg_k     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_count <= '0;
            k_clamped <= 1'b0;
            target    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    avg_rst <= 1'b1;
                    busy    <= 1'b0;
                    if (start && !stop) begin
                        avg_k     <= k_over ? KW'(K_MAX) : k_req;
                        k_clamped <= k_over;
                        target    <= num_samples;
                        out_count <= '0;
                        busy      <= 1'b1;
                        state     <= FLUSH;
                    end
                end
                // avg_rst stays high one more cycle so the averager reloads
                // its down-counter with the newly latched exponent.
                FLUSH: begin
                    avg_rst <= 1'b0;
                    busy    <= 1'b1;
                    state   <= RUN;
                end
                RUN: begin
                    if (stop) begin
                        // A coincident avg_rdy is deliberately dropped.
                        avg_rst <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else if (avg_rdy) begin
                        out_count <= cnt_inc;
                        if ((target != '0) && (cnt_inc == target)) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            avg_rst <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    avg_rst <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    avg_rst <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decimation_controller.sv
module tb_decimation_controller;

    localparam int BITS_ADC  = 8;
    localparam int BITS_ACUM = 13;   // BIT_DIFF = 5, KW = 3
    localparam int BITS_CNT  = 4;
    localparam int KW        = 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic                clk;
    logic                rst;
    logic                start;
    logic                stop;
    logic [KW-1:0]       k_req;
    logic [BITS_CNT-1:0] num_samples;
    logic                adc_rdy;
    logic                avg_rdy;
    logic                avg_rst;
    logic [KW-1:0]       avg_k;
    logic                avg_rdy_in;
    logic                busy;
    logic                done;
    logic [BITS_CNT-1:0] out_count;
    logic                k_clamped;
    logic [1:0]          state_dbg;

    int errors = 0;
    int checks = 0;
    int fwd_cnt = 0;

    // behavioural averager
    int   m_cnt;
    logic m_rdy;
    logic use_model;
    logic force_rdy;

    decimation_controller #(
        .BITS_ADC (BITS_ADC),
        .BITS_ACUM(BITS_ACUM),
        .BITS_CNT (BITS_CNT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .k_req      (k_req),
        .num_samples(num_samples),
        .adc_rdy    (adc_rdy),
        .avg_rdy    (avg_rdy),
        .avg_rst    (avg_rst),
        .avg_k      (avg_k),
        .avg_rdy_in (avg_rdy_in),
        .busy       (busy),
        .done       (done),
        .out_count  (out_count),
        .k_clamped  (k_clamped),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Averager: output n follows the n*2^k-th forwarded strobe by one cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= 0;
            m_rdy <= 1'b0;
        end else if (avg_rst) begin
            m_cnt <= 0;
            m_rdy <= 1'b0;
        end else begin
            m_rdy <= 1'b0;
            if (avg_rdy_in) begin
                if (m_cnt == (1 << avg_k) - 1) begin
                    m_cnt <= 0;
                    m_rdy <= 1'b1;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    assign avg_rdy = use_model ? m_rdy : force_rdy;

    always @(posedge clk) begin
        if (avg_rdy_in) fwd_cnt <= fwd_cnt + 1;
    end

    // driver: present an accepted start, leave the bench at the FLUSH negedge
    task automatic drive_start(input logic [KW-1:0] k, input logic [BITS_CNT-1:0] n);
        @(negedge clk);
        k_req = k;
        num_samples = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0; stop = 1'b0; k_req = '0; num_samples = '0;
        adc_rdy = 1'b0; use_model = 1'b1; force_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", state_dbg, S_IDLE); end
        checks++; if (avg_rst !== 1'b1) begin errors++; $display("FAIL reset_avg_rst: got %0b want 1", avg_rst); end
        checks++; if (avg_k !== 3'd0) begin errors++; $display("FAIL reset_avg_k: got %0d want 0", avg_k); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %0b%0b want 00", busy, done); end
        checks++; if (out_count !== 4'd0 || k_clamped !== 1'b0) begin errors++; $display("FAIL reset_cnt_clamp: got %0d/%0b want 0/0", out_count, k_clamped); end
        rst = 1'b0;
        adc_rdy = 1'b1;
        #1;
        checks++; if (avg_rdy_in !== 1'b0) begin errors++; $display("FAIL idle_gate: got %0b want 0", avg_rdy_in); end
        @(negedge clk);
        adc_rdy = 1'b0;
        checks++; if (state_dbg !== S_IDLE || avg_rst !== 1'b1) begin errors++; $display("FAIL idle_after_reset: got state %0d avg_rst %0b want 0/1", state_dbg, avg_rst); end
    endtask

    task automatic test_basic();
        logic pend;
        int   exp_cnt;
        int   f0;
        bit   got_done;
        drive_start(3'd2, 4'd3);
        checks++; if (state_dbg !== S_FLUSH) begin errors++; $display("FAIL basic_flush_state: got %0d want %0d", state_dbg, S_FLUSH); end
        checks++; if (busy !== 1'b1 || avg_rst !== 1'b1) begin errors++; $display("FAIL basic_flush_busy_rst: got %0b/%0b want 1/1", busy, avg_rst); end
        checks++; if (avg_k !== 3'd2 || k_clamped !== 1'b0) begin errors++; $display("FAIL basic_flush_k: got %0d/%0b want 2/0", avg_k, k_clamped); end
        adc_rdy = 1'b1;
        #1;
        checks++; if (avg_rdy_in !== 1'b0) begin errors++; $display("FAIL basic_flush_gate: got %0b want 0", avg_rdy_in); end
        f0 = fwd_cnt;
        @(negedge clk);
        checks++; if (state_dbg !== S_RUN || avg_rst !== 1'b0) begin errors++; $display("FAIL basic_run_entry: got state %0d avg_rst %0b want 2/0", state_dbg, avg_rst); end
        exp_cnt = 0;
        got_done = 0;
        for (int i = 0; i < 100 && !got_done; i++) begin
            adc_rdy = (i % 2 == 0);
            pend = avg_rdy;
            if (i == 0) begin
                #1;
                checks++; if (avg_rdy_in !== 1'b1) begin errors++; $display("FAIL basic_first_fwd: got %0b want 1", avg_rdy_in); end
            end
            @(negedge clk);
            if (pend) exp_cnt++;
            checks++; if (out_count !== 4'(exp_cnt)) begin errors++; $display("FAIL basic_count: got %0d want %0d", out_count, exp_cnt); end
            if (exp_cnt == 3) begin
                got_done = 1;
                checks++; if (done !== 1'b1 || state_dbg !== S_DONE) begin errors++; $display("FAIL basic_done: got done %0b state %0d want 1/3", done, state_dbg); end
                checks++; if (busy !== 1'b0 || avg_rst !== 1'b1) begin errors++; $display("FAIL basic_done_outs: got busy %0b avg_rst %0b want 0/1", busy, avg_rst); end
            end else begin
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_early_done: got %0b want 0", done); end
            end
        end
        adc_rdy = 1'b0;
        checks++; if (!got_done) begin errors++; $display("FAIL basic_timeout: got %0d outputs want 3", exp_cnt); end
        checks++; if (fwd_cnt - f0 != 12) begin errors++; $display("FAIL basic_strobes: got %0d want 12", fwd_cnt - f0); end
        @(negedge clk);
        checks++; if (state_dbg !== S_IDLE || done !== 1'b0 || avg_rst !== 1'b1) begin errors++; $display("FAIL basic_idle: got state %0d done %0b avg_rst %0b want 0/0/1", state_dbg, done, avg_rst); end
        checks++; if (out_count !== 4'd3) begin errors++; $display("FAIL basic_hold: got %0d want 3", out_count); end
    endtask

    task automatic test_clamp();
        logic pend;
        int   exp_cnt;
        int   f0;
        bit   got_done;
        drive_start(3'd6, 4'd1);
        checks++; if (avg_k !== 3'd4 || k_clamped !== 1'b1) begin errors++; $display("FAIL clamp_k: got %0d/%0b want 4/1", avg_k, k_clamped); end
        f0 = fwd_cnt;
        @(negedge clk);
        exp_cnt = 0;
        got_done = 0;
        for (int i = 0; i < 100 && !got_done; i++) begin
            adc_rdy = (i < 16);
            pend = avg_rdy;
            @(negedge clk);
            if (pend) exp_cnt++;
            checks++; if (out_count !== 4'(exp_cnt) || done !== (exp_cnt == 1)) begin errors++; $display("FAIL clamp_count: got %0d/%0b want %0d/%0b", out_count, done, exp_cnt, exp_cnt == 1); end
            if (exp_cnt == 1) got_done = 1;
        end
        adc_rdy = 1'b0;
        checks++; if (!got_done) begin errors++; $display("FAIL clamp_timeout: got %0d outputs want 1", exp_cnt); end
        checks++; if (fwd_cnt - f0 != 16) begin errors++; $display("FAIL clamp_strobes: got %0d want 16", fwd_cnt - f0); end
        @(negedge clk);
    endtask

    task automatic test_abort();
        drive_start(3'd0, 4'd5);
        @(negedge clk);                // RUN
        adc_rdy = 1'b1;
        @(negedge clk);
        adc_rdy = 1'b1;                // first output pending now
        @(negedge clk);
        checks++; if (out_count !== 4'd1) begin errors++; $display("FAIL abort_pre: got %0d want 1", out_count); end
        checks++; if (avg_rdy !== 1'b1) begin errors++; $display("FAIL abort_setup: got avg_rdy %0b want 1", avg_rdy); end
        adc_rdy = 1'b0;
        stop = 1'b1;                   // coincident with second avg_rdy
        @(negedge clk);
        stop = 1'b0;
        checks++; if (state_dbg !== S_IDLE || busy !== 1'b0 || avg_rst !== 1'b1) begin errors++; $display("FAIL abort_idle: got state %0d busy %0b avg_rst %0b want 0/0/1", state_dbg, busy, avg_rst); end
        checks++; if (out_count !== 4'd1 || done !== 1'b0) begin errors++; $display("FAIL abort_count: got %0d/%0b want 1/0", out_count, done); end
        use_model = 1'b0;
        force_rdy = 1'b1;              // late averager output
        @(negedge clk);
        force_rdy = 1'b0;
        use_model = 1'b1;
        checks++; if (out_count !== 4'd1 || done !== 1'b0 || state_dbg !== S_IDLE) begin errors++; $display("FAIL abort_late: got %0d/%0b/%0d want 1/0/0", out_count, done, state_dbg); end
    endtask

    task automatic test_continuous();
        logic pend;
        int   exp_cnt;
        drive_start(3'd0, 4'd0);
        @(negedge clk);
        exp_cnt = 0;
        for (int i = 0; i < 19; i++) begin
            adc_rdy = (i < 17);
            pend = avg_rdy;
            @(negedge clk);
            if (pend) exp_cnt++;
            checks++; if (out_count !== 4'(exp_cnt % 16)) begin errors++; $display("FAIL cont_count: got %0d want %0d", out_count, exp_cnt % 16); end
            checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL cont_flags: got done %0b busy %0b want 0/1", done, busy); end
        end
        adc_rdy = 1'b0;
        checks++; if (out_count !== 4'd1) begin errors++; $display("FAIL cont_wrap: got %0d want 1", out_count); end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++; if (busy !== 1'b0 || state_dbg !== S_IDLE || done !== 1'b0) begin errors++; $display("FAIL cont_stop: got busy %0b state %0d done %0b want 0/0/0", busy, state_dbg, done); end
    endtask

    task automatic test_config();
        drive_start(3'd1, 4'd0);
        @(negedge clk);                // RUN
        k_req = 3'd3;
        @(negedge clk);
        @(negedge clk);
        checks++; if (avg_k !== 3'd1) begin errors++; $display("FAIL cfg_k_run: got %0d want 1", avg_k); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (state_dbg !== S_RUN || avg_rst !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL cfg_start_run: got state %0d avg_rst %0b busy %0b want 2/0/1", state_dbg, avg_rst, busy); end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++; if (state_dbg !== S_IDLE) begin errors++; $display("FAIL cfg_stop: got %0d want 0", state_dbg); end
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        checks++; if (state_dbg !== S_IDLE || busy !== 1'b0 || avg_rst !== 1'b1) begin errors++; $display("FAIL cfg_start_stop: got state %0d busy %0b avg_rst %0b want 0/0/1", state_dbg, busy, avg_rst); end
        checks++; if (avg_k !== 3'd1) begin errors++; $display("FAIL cfg_k_unlatched: got %0d want 1", avg_k); end
    endtask

    task automatic test_async_reset();
        logic pend;
        int   exp_cnt;
        bit   got_done;
        drive_start(3'd7, 4'd0);
        checks++; if (avg_k !== 3'd4 || k_clamped !== 1'b1) begin errors++; $display("FAIL ares_clamp: got %0d/%0b want 4/1", avg_k, k_clamped); end
        @(negedge clk);
        for (int i = 0; i < 18; i++) begin
            adc_rdy = (i < 16);
            @(negedge clk);
        end
        adc_rdy = 1'b0;
        checks++; if (out_count !== 4'd1 || state_dbg !== S_RUN) begin errors++; $display("FAIL ares_pre: got %0d/%0d want 1/2", out_count, state_dbg); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (state_dbg !== S_IDLE || avg_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ares_now: got state %0d avg_rst %0b busy %0b done %0b want 0/1/0/0", state_dbg, avg_rst, busy, done); end
        checks++; if (avg_k !== 3'd0 || out_count !== 4'd0 || k_clamped !== 1'b0) begin errors++; $display("FAIL ares_regs: got %0d/%0d/%0b want 0/0/0", avg_k, out_count, k_clamped); end
        @(negedge clk);
        rst = 1'b0;
        drive_start(3'd1, 4'd2);
        checks++; if (state_dbg !== S_FLUSH || avg_k !== 3'd1) begin errors++; $display("FAIL ares_restart: got state %0d k %0d want 1/1", state_dbg, avg_k); end
        @(negedge clk);
        exp_cnt = 0;
        got_done = 0;
        for (int i = 0; i < 50 && !got_done; i++) begin
            adc_rdy = (i < 4);
            pend = avg_rdy;
            @(negedge clk);
            if (pend) exp_cnt++;
            if (exp_cnt == 2) begin
                got_done = 1;
                checks++; if (done !== 1'b1 || out_count !== 4'd2) begin errors++; $display("FAIL ares_done: got %0b/%0d want 1/2", done, out_count); end
            end
        end
        adc_rdy = 1'b0;
        checks++; if (!got_done) begin errors++; $display("FAIL ares_timeout: got %0d outputs want 2", exp_cnt); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_abort();
        test_continuous();
        test_config();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
